// File: rtl/rv_multicycle_control.sv
// Multi-cycle control FSM for the RV32I core: fetch/decode/execute/mem/writeback sequencing.
// Latency (zero-wait memory): branch 3 cycles, ALU/LUI/AUIPC/JAL/JALR/store 4, load 5.
// Backpressure: FETCH holds imem_req until imem_ready, MEM holds dmem_req/dmem_we until dmem_ready.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   opcode, rd, is_*          decoder fields and instruction class flags
//   branch_taken              branch comparator result, used in EXECUTE
//   imem_req/imem_ready       instruction fetch handshake
//   dmem_req/dmem_we/dmem_ready  data access handshake
//   ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel, rf_we, wb_sel  datapath controls
//   retire, trap, trap_cause, state_o                           status
//   cycle_count, instret_count                                  performance counters
//
// Optional feature: define RV_CTRL_PERF_EN to build the performance counters;
// without it both counter ports are tied to zero.

module rv_multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 0,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic             is_alu_imm,
    input  logic             is_alu_reg,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             is_branch,
    input  logic             is_jal,
    input  logic             is_jalr,
    input  logic             is_lui_auipc,
    input  logic             branch_taken,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             alu_a_sel,
    output logic             alu_b_sel,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             retire,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_TRAP      = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_NONE,
        C_LOAD,
        C_STORE,
        C_BRANCH,
        C_JAL,
        C_JALR,
        C_ALU_REG,
        C_ALU_IMM,
        C_LUI,
        C_AUIPC
    } cls_t;

    localparam logic [6:0] OPC_LUI = 7'b0110111;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_IMEM_TO = 2'd2;
    localparam logic [1:0] CAUSE_DMEM_TO = 2'd3;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_JALR  = 2'd2;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;
    localparam logic [1:0] WB_IMM  = 2'd3;

    state_t      state_q, state_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] to_cnt_q;
    logic        to_expired;
    logic        waiting;
    cls_t        cls;

    // Collapse the class flags into one class. Several flags at once should not
    // happen, but the fixed priority keeps the FSM deterministic if they do.
    // Any lui_auipc opcode other than LUI is treated as AUIPC.
    always_comb begin
        cls = C_NONE;
        if (is_load)           cls = C_LOAD;
        else if (is_store)     cls = C_STORE;
        else if (is_branch)    cls = C_BRANCH;
        else if (is_jal)       cls = C_JAL;
        else if (is_jalr)      cls = C_JALR;
        else if (is_alu_reg)   cls = C_ALU_REG;
        else if (is_alu_imm)   cls = C_ALU_IMM;
        else if (is_lui_auipc) cls = (opcode == OPC_LUI) ? C_LUI : C_AUIPC;
    end

    // The wait counter holds the number of completed wait cycles in the current
    // state. The trap fires in the cycle where it already equals MEM_TIMEOUT and
    // ready is still low, so ready arriving in that cycle still wins.
    assign waiting    = ((state_q == ST_FETCH) && !imem_ready) ||
                        ((state_q == ST_MEM)   && !dmem_ready);
    assign to_expired = (MEM_TIMEOUT != 0) && (to_cnt_q == MEM_TIMEOUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RESET;
            cause_q  <= CAUSE_NONE;
            to_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if (state_d != state_q)
                to_cnt_q <= '0;
            else if (waiting && (MEM_TIMEOUT != 0))
                to_cnt_q <= to_cnt_q + 32'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_PLUS4;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = WB_ALU;
        retire    = 1'b0;

        case (state_q)
            ST_RESET: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end else if (to_expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_IMEM_TO;
                end
            end

            ST_DECODE: begin
                if (cls == C_NONE) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end

            ST_EXECUTE: begin
                alu_a_sel = (cls == C_AUIPC) || (cls == C_BRANCH) || (cls == C_JAL);
                alu_b_sel = !((cls == C_ALU_REG) || (cls == C_BRANCH));
                case (cls)
                    C_BRANCH: begin
                        pc_we   = 1'b1;
                        pc_sel  = branch_taken ? PC_IMM : PC_PLUS4;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    C_LOAD, C_STORE: state_d = ST_MEM;
                    default:         state_d = ST_WRITEBACK;
                endcase
            end

            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls == C_STORE);
                if (dmem_ready) begin
                    if (cls == C_STORE) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WRITEBACK;
                    end
                end else if (to_expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_DMEM_TO;
                end
            end

            ST_WRITEBACK: begin
                rf_we = (rd != 5'd0);
                case (cls)
                    C_LOAD:        wb_sel = WB_LOAD;
                    C_JAL, C_JALR: wb_sel = WB_LINK;
                    C_LUI:         wb_sel = WB_IMM;
                    default:       wb_sel = WB_ALU;
                endcase
                pc_we = 1'b1;
                case (cls)
                    C_JAL:   pc_sel = PC_IMM;
                    C_JALR:  pc_sel = PC_JALR;
                    default: pc_sel = PC_PLUS4;
                endcase
                retire  = 1'b1;
                state_d = ST_FETCH;
            end

            ST_TRAP: begin
                state_d = ST_TRAP;
            end

            // Encoding 6 is unreachable; restart cleanly if it is ever seen.
            default: begin
                state_d = ST_RESET;
                cause_d = CAUSE_NONE;
            end
        endcase
    end

    assign trap       = (state_q == ST_TRAP);
    assign trap_cause = cause_q;
    assign state_o    = state_q;

`ifdef RV_CTRL_PERF_EN
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if ((state_q != ST_RESET) && (state_q != ST_TRAP))
                cycle_q <= cycle_q + CNT_W'(1);
            if (retire)
                instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;
`else
    assign cycle_count   = '0;
    assign instret_count = '0;
`endif

endmodule
